// File: rtl/keyboard_command_sender_pkg.sv
// Shared types and constants for the PS/2 host-to-device command path.
// States, well-known command bytes and default timing values.
package keyboard_command_sender_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    RELEASE,
    DONE
  } kcs_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ACK_BYTE = 8'hFA;

  localparam int DEF_INHIBIT_CYCLES = 5000;
  localparam int DEF_START_CYCLES   = 10;
  localparam int DEF_TIMEOUT_CYCLES = 750000;

  // Stop bit, odd parity, data; shifted out LSB first.
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins.
// Also flags a falling edge of the synchronized clock.
module ps2_line_sync (
  input  logic clk_50,
  input  logic reset_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_in};
      dat_ff   <= {dat_ff[0], dat_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];
  assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/keyboard_command_sender.sv
// PS/2 host-to-device transmitter: inhibit, start, 10 bits, ack.
// Open-drain pins driven via output enables; all outputs registered.
module keyboard_command_sender
  import keyboard_command_sender_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_CYCLES   = DEF_START_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       done,
  output logic       error,
  output logic       rx_hold,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE
);

  localparam int MAX_A = (INHIBIT_CYCLES > START_CYCLES) ?
                         INHIBIT_CYCLES : START_CYCLES;
  localparam int MAX_C = (TIMEOUT_CYCLES > MAX_A) ?
                         TIMEOUT_CYCLES : MAX_A;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] STA_LAST = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic clk_sync;
  logic dat_sync;
  logic clk_fall;

  ps2_line_sync u_sync (
    .clk_50   (clk_50),
    .reset_n  (reset_n),
    .clk_in   (PS2_CLK_IN),
    .dat_in   (PS2_DAT_IN),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .clk_fall (clk_fall)
  );

  kcs_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          ack_err_q, ack_err_d;
  logic          error_q, error_d;
  logic          dat_oe_q, dat_oe_d;
  logic          clk_oe_q, clk_oe_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          hold_q, hold_d;
  logic          to_hit;

  assign to_hit = (cnt_q == TO_LAST);

  // Next state, counters, frame shifting and next registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    ack_err_d = ack_err_q;
    error_d   = error_q;
    dat_oe_d  = dat_oe_q;
    unique case (state_q)
      IDLE: begin
        dat_oe_d = 1'b0;
        if (cmd_valid && ready_q) begin
          state_d   = INHIBIT;
          frame_d   = ps2_frame(cmd_byte);
          bit_d     = 4'd0;
          cnt_d     = '0;
          ack_err_d = 1'b0;
          error_d   = 1'b0;
        end
      end
      INHIBIT: begin
        dat_oe_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          state_d  = START;
          cnt_d    = '0;
          dat_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      START: begin
        dat_oe_d = 1'b1;
        if (cnt_q == STA_LAST) begin
          state_d = SEND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SEND: begin
        if (to_hit) begin
          state_d  = DONE;
          dat_oe_d = 1'b0;
          error_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (clk_fall) begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd9) begin
              dat_oe_d = 1'b0;
              state_d  = ACK;
            end else begin
              dat_oe_d = ~frame_q[0];
              frame_d  = frame_q >> 1;
            end
          end
        end
      end
      ACK: begin
        dat_oe_d = 1'b0;
        if (to_hit) begin
          state_d = DONE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (clk_fall) begin
            ack_err_d = dat_sync;
            state_d   = RELEASE;
          end
        end
      end
      RELEASE: begin
        dat_oe_d = 1'b0;
        if (to_hit) begin
          state_d = DONE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (clk_sync && dat_sync) begin
            state_d = DONE;
            error_d = ack_err_q;
          end
        end
      end
      DONE: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    clk_oe_d = (state_d == INHIBIT) || (state_d == START);
    ready_d  = (state_d == IDLE);
    done_d   = (state_d == DONE);
    hold_d   = (state_d != IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 4'd0;
      frame_q   <= 10'd0;
      ack_err_q <= 1'b0;
      error_q   <= 1'b0;
      dat_oe_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      ack_err_q <= ack_err_d;
      error_q   <= error_d;
      dat_oe_q  <= dat_oe_d;
      clk_oe_q  <= clk_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign done       = done_q;
  assign error      = error_q;
  assign rx_hold    = hold_q;
  assign PS2_CLK_OE = clk_oe_q;
  assign PS2_DAT_OE = dat_oe_q;

endmodule
